// File: rtl/l2_resp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : l2_resp_engine
//  Description : Fixed-latency L2 response model. It accepts one request at a
//                time, waits LATENCY cycles and then returns the line.
//                Reads and writes go to a backing array. Writes can cover the
//                full line or a byte, half or word.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_resp_engine #(
    parameter int BLK_SIZE  = 128,
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    input  logic [31:0]         req_addr_i,
    input  logic                req_rw_i,
    input  logic [1:0]          req_rw_size_i,
    input  logic [BLK_SIZE-1:0] req_data_i,
    input  logic                req_uncached_i,
    input  logic [3:0]          req_id_i,
    output logic                res_valid_o,
    output logic                res_ready_o,
    output logic [BLK_SIZE-1:0] res_blk_o,
    output logic [3:0]          res_id_o
);

    localparam int         NBYTES   = BLK_SIZE / 8;
    localparam int         BOFF     = $clog2(NBYTES);
    localparam int         IDX      = $clog2(MEM_LINES);
    localparam logic [7:0] CNT_LOAD = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    localparam logic [1:0] SZ_LINE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic [31:0]         addr_q;
    logic                rw_q;
    logic [1:0]          size_q;
    logic [BLK_SIZE-1:0] data_q;
    logic                uncached_q;
    logic [3:0]          id_q;

    logic [BLK_SIZE-1:0] mem [MEM_LINES];

    // The response line is built either from the live request (LATENCY=1
    // enters RESP straight from IDLE) or from the latched copy.
    logic                from_inputs;
    logic [31:0]         src_addr;
    logic                src_rw;
    logic [1:0]          src_size;
    logic [BLK_SIZE-1:0] src_data;
    logic [3:0]          src_id;
    logic [IDX-1:0]      src_idx;
    logic [BOFF-1:0]     src_off;
    logic [BLK_SIZE-1:0] cur_line;
    logic [BOFF-1:0]     aligned;
    logic [BLK_SIZE-1:0] merged;
    logic                unused_bits;

    assign from_inputs = (state == IDLE);
    assign src_addr    = from_inputs ? req_addr_i    : addr_q;
    assign src_rw      = from_inputs ? req_rw_i      : rw_q;
    assign src_size    = from_inputs ? req_rw_size_i : size_q;
    assign src_data    = from_inputs ? req_data_i    : data_q;
    assign src_id      = from_inputs ? req_id_i      : id_q;
    assign src_idx     = src_addr[BOFF+IDX-1:BOFF];
    assign src_off     = src_addr[BOFF-1:0];
    assign cur_line    = mem[src_idx];

    // Upper address bits wrap away and the uncached flag has no effect on data.
    assign unused_bits = ^{uncached_q, req_uncached_i, src_addr[31:BOFF+IDX]};

    // Post-write line: overlay the sized write at its size-aligned offset.
    always_comb begin
        aligned = src_off;
        merged  = cur_line;
        if (src_rw) begin
            case (src_size)
                SZ_LINE: merged = src_data;
                SZ_BYTE: merged[{aligned, 3'b000} +: 8] = src_data[7:0];
                SZ_HALF: begin
                    aligned[0] = 1'b0;
                    merged[{aligned, 3'b000} +: 16] = src_data[15:0];
                end
                SZ_WORD: begin
                    aligned[1:0] = 2'b00;
                    merged[{aligned, 3'b000} +: 32] = src_data[31:0];
                end
                default: merged = cur_line;
            endcase
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            addr_q      <= 32'd0;
            rw_q        <= 1'b0;
            size_q      <= 2'b00;
            data_q      <= '0;
            uncached_q  <= 1'b0;
            id_q        <= 4'd0;
            res_valid_o <= 1'b0;
            res_ready_o <= 1'b1;
            res_blk_o   <= '0;
            res_id_o    <= 4'd0;
        end else begin
            res_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        rw_q        <= req_rw_i;
                        size_q      <= req_rw_size_i;
                        data_q      <= req_data_i;
                        uncached_q  <= req_uncached_i;
                        id_q        <= req_id_i;
                        cnt         <= CNT_LOAD;
                        res_ready_o <= 1'b0;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            res_valid_o <= 1'b1;
                            res_blk_o   <= merged;
                            res_id_o    <= src_id;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        state       <= RESP;
                        res_valid_o <= 1'b1;
                        res_blk_o   <= merged;
                        res_id_o    <= src_id;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    res_ready_o <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    res_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Write commit on the RESP edge; a reset in that cycle suppresses it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == RESP && rw_q) begin
            mem[addr_q[BOFF+IDX-1:BOFF]] <= res_blk_o;
        end
    end

endmodule
`default_nettype wire
